// File: rtl/mine_placer.sv
// Mine-map generator: clears the board and places exactly MINES distinct mines
// from a free-running maximal-length LFSR, optionally keeping a 3x3 zone clear.
module mine_placer #(
  parameter int COLS   = 8,
  parameter int ROWS   = 8,
  parameter int MINES  = 8,
  parameter int LFSR_W = 16,
  parameter logic [LFSR_W-1:0] SEED = 16'hACE1,
  localparam int CELLS = COLS * ROWS,
  localparam int RW    = $clog2(ROWS),
  localparam int CW    = $clog2(COLS),
  localparam int CNTW  = $clog2(MINES + 1)
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  input  logic              seed_ld,
  input  logic [LFSR_W-1:0] seed,
  input  logic              safe_en,
  input  logic [RW-1:0]     safe_row,
  input  logic [CW-1:0]     safe_col,
  output logic              busy,
  output logic              done,
  output logic [CELLS-1:0]  mine_map,
  output logic [CNTW-1:0]   mine_count
);

  localparam int IDXW = $clog2(CELLS);

  // Fibonacci tap masks (bit t-1 set for tap t) of maximal-length polynomials.
  function automatic logic [31:0] tap_mask(input int w);
    case (w)
      2:       return 32'h0000_0003;
      3:       return 32'h0000_0006;
      4:       return 32'h0000_000C;
      5:       return 32'h0000_0014;
      6:       return 32'h0000_0030;
      7:       return 32'h0000_0060;
      8:       return 32'h0000_00B8;
      9:       return 32'h0000_0110;
      10:      return 32'h0000_0240;
      11:      return 32'h0000_0500;
      12:      return 32'h0000_0829;
      13:      return 32'h0000_100D;
      14:      return 32'h0000_2015;
      15:      return 32'h0000_6000;
      16:      return 32'h0000_B400;
      17:      return 32'h0001_2000;
      18:      return 32'h0002_0400;
      19:      return 32'h0004_0023;
      20:      return 32'h0009_0000;
      21:      return 32'h0014_0000;
      22:      return 32'h0030_0000;
      23:      return 32'h0042_0000;
      24:      return 32'h00E1_0000;
      default: return 32'h0000_0000;
    endcase
  endfunction

  localparam logic [31:0]       TAPS32  = tap_mask(LFSR_W);
  localparam logic [LFSR_W-1:0] TAPS    = TAPS32[LFSR_W-1:0];
  localparam logic [LFSR_W-1:0] ONE     = {{(LFSR_W-1){1'b0}}, 1'b1};
  localparam logic [LFSR_W-1:0] SEED_NZ = (SEED == '0) ? ONE : SEED;

  typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_PLACE, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [LFSR_W-1:0]   lfsr_q, lfsr_shift;
  logic [CELLS-1:0]    map_q;
  logic [CNTW-1:0]     count_q;
  logic                safe_en_q;
  logic [RW-1:0]       safe_row_q;
  logic [CW-1:0]       safe_col_q;

  logic [RW-1:0]       cand_row;
  logic [CW-1:0]       cand_col;
  logic [RW:0]         cr, sr;
  logic [CW:0]         cc, sc;
  logic [IDXW-1:0]     cand_idx;
  logic [CELLS-1:0]    cand_bit;
  logic                in_range, occupied, in_safe, accept, last, start_ok;

  assign lfsr_shift = {lfsr_q[LFSR_W-2:0], ^(lfsr_q & TAPS)};

  assign cand_row = lfsr_q[RW-1:0];
  assign cand_col = lfsr_q[RW+CW-1:RW];
  assign cr       = {1'b0, cand_row};
  assign sr       = {1'b0, safe_row_q};
  assign cc       = {1'b0, cand_col};
  assign sc       = {1'b0, safe_col_q};

  assign in_range = (cr < (RW+1)'(ROWS)) && (cc < (CW+1)'(COLS));
  assign cand_idx = IDXW'(cand_row) * IDXW'(COLS) + IDXW'(cand_col);
  assign cand_bit = {{(CELLS-1){1'b0}}, 1'b1} << cand_idx;
  assign occupied = |(map_q & cand_bit);
  // Chebyshev distance <= 1 on unsigned coordinates; board edges clip, no wrap.
  assign in_safe  = safe_en_q && (cr + 1'b1 >= sr) && (sr + 1'b1 >= cr) &&
                    (cc + 1'b1 >= sc) && (sc + 1'b1 >= cc);
  assign accept   = (state_q == S_PLACE) && in_range && !occupied && !in_safe;
  assign last     = accept && (count_q == CNTW'(MINES - 1));
  assign start_ok = (state_q == S_IDLE) && start;

  // Handshake: start is a level request sampled only in IDLE (never queued);
  // busy is high through CLEAR and PLACE; done is a one-cycle completion pulse
  // that rises on the edge busy falls, after which mine_map is valid.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_CLEAR;
      S_CLEAR: state_d = S_PLACE;
      S_PLACE: if (last) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= S_IDLE;
      lfsr_q     <= SEED_NZ;
      map_q      <= '0;
      count_q    <= '0;
      safe_en_q  <= 1'b0;
      safe_row_q <= '0;
      safe_col_q <= '0;
    end else begin
      state_q <= state_d;
      if ((state_q == S_IDLE) && seed_ld)
        lfsr_q <= (seed == '0) ? ONE : seed;
      else
        lfsr_q <= lfsr_shift;
      if (start_ok) begin
        safe_en_q  <= safe_en;
        safe_row_q <= safe_row;
        safe_col_q <= safe_col;
      end
      if (state_q == S_CLEAR) begin
        map_q   <= '0;
        count_q <= '0;
      end else if (accept) begin
        map_q   <= map_q | cand_bit;
        count_q <= count_q + CNTW'(1);
      end
    end
  end

  assign busy       = (state_q == S_CLEAR) || (state_q == S_PLACE);
  assign done       = (state_q == S_DONE);
  assign mine_map   = map_q;
  assign mine_count = count_q;

endmodule

// File: tb/tb_mine_placer.sv
// Bench for mine_placer: default 8x8/8-mine instance and a 10x6/51-mine
// instance, checked every cycle against a transaction-level placement model.
module tb_mine_placer;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- stimulus signals (index 0: 8x8, 1: 10x6) ----------------
  logic        start_v[2];
  logic        seed_ld_v[2];
  logic [15:0] seed_v[2];
  logic        safe_en_v[2];
  logic [3:0]  safe_row_v[2];
  logic [3:0]  safe_col_v[2];

  logic        busy_a, done_a, busy_b, done_b;
  logic [63:0] map_a;
  logic [59:0] map_b;
  logic [3:0]  cnt_a;
  logic [5:0]  cnt_b;

  mine_placer u_a (
    .clk(clk), .resetn(resetn), .start(start_v[0]), .seed_ld(seed_ld_v[0]),
    .seed(seed_v[0]), .safe_en(safe_en_v[0]), .safe_row(safe_row_v[0][2:0]),
    .safe_col(safe_col_v[0][2:0]), .busy(busy_a), .done(done_a),
    .mine_map(map_a), .mine_count(cnt_a)
  );

  mine_placer #(.COLS(10), .ROWS(6), .MINES(51)) u_b (
    .clk(clk), .resetn(resetn), .start(start_v[1]), .seed_ld(seed_ld_v[1]),
    .seed(seed_v[1]), .safe_en(safe_en_v[1]), .safe_row(safe_row_v[1][2:0]),
    .safe_col(safe_col_v[1][3:0]), .busy(busy_b), .done(done_b),
    .mine_map(map_b), .mine_count(cnt_b)
  );

  // ---------------- scoreboard counters ----------------
  int n_cmp = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- behavioural model ----------------
  int p_cols[2]  = '{8, 10};
  int p_rows[2]  = '{8, 6};
  int p_mines[2] = '{8, 51};
  int p_rw[2]    = '{3, 3};
  int p_cw[2]    = '{3, 4};

  typedef struct {
    logic [63:0] map;
    int          n;
  } pred_t;

  // x^16+x^14+x^13+x^11+1, shifting toward the MSB.
  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  // Replays the candidate stream starting with value l0 and returns the final
  // map plus the number of PLACE cycles spent.
  function automatic pred_t predict(input logic [15:0] l0, input int i,
                                    input bit se, input int sr, input int sc);
    pred_t p;
    logic [15:0] l;
    int placed, r, c;
    p.map = '0;
    p.n = 0;
    l = l0;
    placed = 0;
    while (placed < p_mines[i] && p.n < 70000) begin
      r = int'(l) % (1 << p_rw[i]);
      c = (int'(l) >> p_rw[i]) % (1 << p_cw[i]);
      p.n++;
      if (r < p_rows[i] && c < p_cols[i] && !p.map[r*p_cols[i]+c] &&
          !(se && (r - sr) <= 1 && (sr - r) <= 1 && (c - sc) <= 1 && (sc - c) <= 1)) begin
        p.map[r*p_cols[i]+c] = 1'b1;
        placed++;
      end
      l = lfsr_next(l);
    end
    return p;
  endfunction

  function automatic logic [63:0] pred_map(input logic [15:0] l0, input int i,
                                           input bit se, input int sr, input int sc);
    pred_t p;
    p = predict(l0, i, se, sr, sc);
    return p.map;
  endfunction

  function automatic int pred_n(input logic [15:0] l0, input int i,
                                input bit se, input int sr, input int sc);
    pred_t p;
    p = predict(l0, i, se, sr, sc);
    return p.n;
  endfunction

  logic [15:0] m_lfsr[2];
  logic [63:0] m_map[2];
  int          m_k[2];
  int          m_n[2];
  bit          m_act[2];

  // A start at edge e is accepted if no run is active or the last one left DONE.
  function automatic bit is_idle(input int i, input int e);
    return !m_act[i] || (e >= m_k[i] + m_n[i] + 3);
  endfunction

  function automatic logic [15:0] next_l(input int i, input int e);
    if (is_idle(i, e) && seed_ld_v[i])
      return (seed_v[i] == 16'h0) ? 16'h0001 : seed_v[i];
    return lfsr_next(m_lfsr[i]);
  endfunction

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < 2; i++) begin
        m_lfsr[i] <= 16'hACE1;
        m_map[i]  <= '0;
        m_k[i]    <= 0;
        m_n[i]    <= 0;
        m_act[i]  <= 1'b0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        m_lfsr[i] <= next_l(i, cyc + 1);
        if (is_idle(i, cyc + 1) && start_v[i]) begin
          m_act[i] <= 1'b1;
          m_k[i]   <= cyc + 1;
          m_n[i]   <= pred_n(lfsr_next(next_l(i, cyc + 1)), i, safe_en_v[i],
                             int'(safe_row_v[i]), int'(safe_col_v[i]));
          m_map[i] <= pred_map(lfsr_next(next_l(i, cyc + 1)), i, safe_en_v[i],
                               int'(safe_row_v[i]), int'(safe_col_v[i]));
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      automatic bit eb = m_act[i] && cyc >= m_k[i] && cyc <= m_k[i] + m_n[i];
      automatic bit ed = m_act[i] && cyc == m_k[i] + m_n[i] + 1;
      automatic logic [63:0] ec = m_act[i] ? 64'(p_mines[i]) : 64'h0;
      check($sformatf("busy[%0d]", i), (i == 0) ? 64'(busy_a) : 64'(busy_b), 64'(eb));
      check($sformatf("done[%0d]", i), (i == 0) ? 64'(done_a) : 64'(done_b), 64'(ed));
      if (!eb) begin
        check($sformatf("map[%0d]", i), (i == 0) ? map_a : 64'(map_b), m_map[i]);
        check($sformatf("count[%0d]", i), (i == 0) ? 64'(cnt_a) : 64'(cnt_b), ec);
      end
    end
  end

  // ---------------- driver tasks ----------------
  function automatic bit done_of(input int i);
    return (i == 0) ? done_a : done_b;
  endfunction

  task automatic do_run(input int i, input bit ld, input logic [15:0] sd,
                        input bit se, input int sr, input int sc, output int lat);
    int k0;
    @(negedge clk); #1;
    seed_ld_v[i]  = ld;
    seed_v[i]     = sd;
    safe_en_v[i]  = se;
    safe_row_v[i] = 4'(sr);
    safe_col_v[i] = 4'(sc);
    start_v[i]    = 1'b1;
    @(posedge clk); #1;
    k0 = cyc;
    start_v[i]   = 1'b0;
    seed_ld_v[i] = 1'b0;
    lat = -1;
    for (int t = 0; t < 20000; t++) begin
      @(negedge clk);
      if (done_of(i)) begin
        lat = cyc - k0 + 1;
        break;
      end
    end
    check($sformatf("done_timeout[%0d]", i), 64'(lat < 0), 64'h0);
    check($sformatf("latency_bounds[%0d]", i),
          64'(lat >= p_mines[i] + 2 && lat < 65536), 64'h1);
  endtask

  // ---------------- directed sequence ----------------
  logic [63:0] saved_map;
  logic [59:0] exp_b;
  int          lat, extra_done, k0;
  int          safe_b[9] = '{14, 15, 16, 24, 25, 26, 34, 35, 36};

  initial begin
    for (int i = 0; i < 2; i++) begin
      start_v[i] = 1'b0; seed_ld_v[i] = 1'b0; seed_v[i] = 16'h0;
      safe_en_v[i] = 1'b0; safe_row_v[i] = 4'h0; safe_col_v[i] = 4'h0;
    end
    repeat (3) @(negedge clk);
    #1 resetn = 1'b1;
    @(negedge clk);
    check("reset_map", map_a, 64'h0);
    check("reset_count", 64'(cnt_a), 64'h0);
    check("reset_busy", 64'(busy_a), 64'h0);
    check("reset_done", 64'(done_a), 64'h0);

    // seed=1, no safe zone
    do_run(0, 1'b1, 16'h0001, 1'b0, 0, 0, lat);
    check("seed1_popcount", 64'($countones(map_a)), 64'd8);
    check("seed1_count", 64'(cnt_a), 64'd8);
    check("seed1_busy_with_done", 64'(busy_a), 64'h0);
    saved_map = map_a;
    @(negedge clk);
    check("done_pulse_width", 64'(done_a), 64'h0);

    // seed=0 loads as 1: same timing gives the same map
    do_run(0, 1'b1, 16'h0000, 1'b0, 0, 0, lat);
    check("seed0_eq_seed1", map_a, saved_map);

    // safe zone at the corner and in the interior
    do_run(0, 1'b1, 16'h0001, 1'b1, 0, 0, lat);
    check("safe00_clear", map_a & 64'h0000_0000_0000_0303, 64'h0);
    check("safe00_count", 64'(cnt_a), 64'd8);
    do_run(0, 1'b0, 16'h0000, 1'b1, 4, 4, lat);
    check("safe44_clear", map_a & 64'h0000_3838_3800_0000, 64'h0);
    check("safe44_count", 64'(cnt_a), 64'd8);

    // 10x6 board, 51 mines, safe at row 2 col 5: every free cell is a mine
    exp_b = '1;
    foreach (safe_b[j]) exp_b[safe_b[j]] = 1'b0;
    do_run(1, 1'b1, 16'h1234, 1'b1, 2, 5, lat);
    check("b_full_map", 64'(map_b), 64'(exp_b));
    check("b_count", 64'(cnt_b), 64'd51);

    // reset five cycles into PLACE
    @(negedge clk); #1 start_v[0] = 1'b1;
    @(posedge clk); #1 start_v[0] = 1'b0;
    repeat (6) @(posedge clk);
    #2 resetn = 1'b0;
    #1;
    check("midreset_map", map_a, 64'h0);
    check("midreset_busy", 64'(busy_a), 64'h0);
    check("midreset_done", 64'(done_a), 64'h0);
    check("midreset_count", 64'(cnt_a), 64'h0);
    @(negedge clk); @(negedge clk);
    #1 resetn = 1'b1;
    do_run(0, 1'b0, 16'h0000, 1'b0, 0, 0, lat);
    check("after_reset_count", 64'(cnt_a), 64'd8);

    // start and seed_ld while busy, start during DONE: all ignored
    @(negedge clk); #1 start_v[0] = 1'b1;
    @(posedge clk); #1 start_v[0] = 1'b0;
    k0 = cyc;
    lat = -1;
    for (int t = 0; t < 20000; t++) begin
      @(negedge clk);
      if (done_a) begin
        lat = cyc - k0 + 1;
        break;
      end
      #1;
      if (t == 2 || t == 5) begin
        start_v[0] = 1'b1; seed_ld_v[0] = 1'b1; seed_v[0] = 16'h5555;
      end else begin
        start_v[0] = 1'b0; seed_ld_v[0] = 1'b0;
      end
    end
    check("busy_run_timeout", 64'(lat < 0), 64'h0);
    #1 start_v[0] = 1'b1;
    @(negedge clk);
    check("start_in_done_ignored", 64'(busy_a), 64'h0);
    #1 start_v[0] = 1'b0;
    extra_done = 0;
    for (int t = 0; t < 30; t++) begin
      @(negedge clk);
      if (done_a) extra_done++;
    end
    check("no_extra_done", 64'(extra_done), 64'h0);

    // follow-up run without reseeding: exposes any LFSR disturbance
    do_run(0, 1'b0, 16'h0000, 1'b0, 0, 0, lat);
    check("followup_count", 64'(cnt_a), 64'd8);

    repeat (5) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
